// File: rtl/tx_pkg.sv
// tx_pkg: shared types, PRBS-31 constants and step function for the TX word feeder.
// Contents:
//   tx_mode_e    - encoding of the 2-bit mode input (IDLE, CLKPAT, DATA, PRBS)
//   tx_state_e   - feeder FSM states
//   PRBS31_*     - polynomial x^31 + x^28 + 1 expressed as state-bit taps
//   prbs31_step  - advance an LFSR n steps, returning new state and the n bits (bit 0 oldest)
package tx_pkg;
    typedef enum logic [1:0] {IDLE, CLKPAT, DATA, PRBS} tx_mode_e;
    typedef enum logic [1:0] {S_IDLE, S_CLKPAT, S_DATA, S_PRBS} tx_state_e;
    localparam int PRBS31_LEN    = 31;
    // state[0] is the newest bit, so state[30] is 31 bits back and state[27] is 28 back
    localparam int PRBS31_TAP_HI = 30;
    localparam int PRBS31_TAP_LO = 27;
    localparam int PRBS_MAX_BITS = 64;
    typedef struct packed {
        logic [PRBS31_LEN-1:0]    state;
        logic [PRBS_MAX_BITS-1:0] bits;
    } prbs_res_t;
    function automatic prbs_res_t prbs31_step(input logic [PRBS31_LEN-1:0] state, input int n);
        prbs_res_t r;
        logic nb;
        r.state = state;
        r.bits  = '0;
        for (int i = 0; i < PRBS_MAX_BITS; i++) begin
            if (i < n) begin
                nb        = r.state[PRBS31_TAP_HI] ^ r.state[PRBS31_TAP_LO];
                r.bits[i] = nb;
                r.state   = {r.state[PRBS31_LEN-2:0], nb};
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/tx_word_fifo.sv
// tx_word_fifo: small synchronous FIFO buffering link-layer words for the feeder.
// Ports:
//   clk, rstb       - clock, asynchronous active-low reset
//   flush           - synchronous clear; a push or pop in the same cycle is dropped
//   push, wdata     - write request and word (ignored when full)
//   pop, rdata      - read request (ignored when empty) and head-of-queue word
//   full, empty     - occupancy flags decoded from the registered count
//   count           - number of stored words, 0..DEPTH
module tx_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= (do_push && !do_pop) ? count + 1'b1 :
                     (do_pop && !do_push) ? count - 1'b1 : count;
        end
    end
endmodule

// File: rtl/tx_word_feeder.sv
// tx_word_feeder: per-cycle word source for the TX serializer (idle, clock pattern, FIFO data, PRBS-31).
// Ports:
//   clk, rstb        - word clock, asynchronous active-low reset
//   mode             - 0 idle, 1 clock pattern, 2 data, 3 PRBS (registered before use)
//   flush            - synchronous FIFO clear
//   in_valid/in_data - link-layer word offered to the FIFO
//   in_ready         - FIFO has room (decoded from registered count)
//   dout             - registered word to serializer din, bit 0 sent first
//   dout_is_data     - dout carries a FIFO word this cycle
//   underrun_cnt     - saturating count of data-mode cycles with an empty FIFO
// Build option: define TX_WORD_FEEDER_PRBS_EN to build the PRBS-31 generator;
// without it mode 3 behaves as idle and PRBS_SEED is unused.
module tx_word_feeder
    import tx_pkg::*;
#(
    parameter int                         WIDTH     = 32,
    parameter int                         DEPTH     = 4,
    parameter logic [PRBS31_LEN-1:0]      PRBS_SEED = 31'h7FFF_FFFF
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [1:0]       mode,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_is_data,
    output logic [7:0]       underrun_cnt
);
    tx_mode_e         mode_r;
    tx_state_e        state, state_nxt;
    logic             full, empty, push, pop, underrun;
    logic [WIDTH-1:0] head, prbs_word, word_nxt;
`ifdef TX_WORD_FEEDER_PRBS_EN
    localparam tx_state_e             MODE3_STATE = S_PRBS;
    localparam logic [PRBS31_LEN-1:0] SEED        = (PRBS_SEED == '0) ? 31'h1 : PRBS_SEED;
    logic [PRBS31_LEN-1:0] lfsr;
    prbs_res_t             step;
    assign step      = prbs31_step(lfsr, WIDTH);
    assign prbs_word = step.bits[WIDTH-1:0];
    // the generator only advances while its words are being emitted, so re-entry resumes the sequence
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) lfsr <= SEED;
        else if (state == S_PRBS) lfsr <= step.state;
    end
`else
    localparam tx_state_e MODE3_STATE = S_IDLE;
    assign prbs_word = '0;
`endif
    tx_word_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstb  (rstb),
        .flush (flush),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count ()
    );
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = state == S_DATA && !empty && !flush;
    assign underrun = state == S_DATA && empty;
    always_comb begin
        state_nxt = mode_r == CLKPAT ? S_CLKPAT :
                    mode_r == DATA   ? S_DATA   :
                    mode_r == PRBS   ? MODE3_STATE : S_IDLE;
        word_nxt  = state == S_CLKPAT ? {WIDTH/2{2'b10}} :
                    pop               ? head :
                    state == S_PRBS   ? prbs_word : '0;
    end
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            mode_r       <= IDLE;
            state        <= S_IDLE;
            dout         <= '0;
            dout_is_data <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            mode_r       <= tx_mode_e'(mode);
            state        <= state_nxt;
            dout         <= word_nxt;
            dout_is_data <= pop;
            if (underrun && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_tx_word_feeder.sv
// tb_tx_word_feeder: directed self-checking bench for tx_word_feeder.
module tb_tx_word_feeder;
    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, dout_is_data;
    logic [31:0] dout;
    logic [7:0]  underrun_cnt;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    tx_word_feeder #(.WIDTH(32), .DEPTH(4), .PRBS_SEED(31'h7FFF_FFFF)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .mode         (mode),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .dout         (dout),
        .dout_is_data (dout_is_data),
        .underrun_cnt (underrun_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [31:0] words [4] = '{32'h0000_0001, 32'hDEAD_BEEF, 32'hFFFF_0000, 32'h1234_5678};
    logic [31:0] e_dout [10] = '{32'h0, 32'h0, 32'h0000_0001, 32'hDEAD_BEEF, 32'hFFFF_0000,
                                 32'h1234_5678, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0};
    logic        e_isd [10] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [7:0]  e_cnt [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3};
    logic        e_rdy [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1};

`ifdef TX_WORD_FEEDER_PRBS_EN
    bit          hist [$];
    logic [31:0] pw;
`endif

    initial begin
        #2;
        chk("rst_dout", dout, 32'h0);
        chk("rst_isd", {31'b0, dout_is_data}, 32'h0);
        chk("rst_rdy", {31'b0, in_ready}, 32'h1);
        chk("rst_cnt", {24'b0, underrun_cnt}, 32'h0);
        @(negedge clk);
        rstb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("idle_dout", dout, 32'h0);
            chk("idle_rdy", {31'b0, in_ready}, 32'h1);
            chk("idle_cnt", {24'b0, underrun_cnt}, 32'h0);
        end
        // fill the FIFO while idle
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            tick;
            chk("fill_rdy", {31'b0, in_ready}, {31'b0, i < 3});
            chk("fill_dout", dout, 32'h0);
        end
        // a fifth word is held against a full FIFO while data mode starts
        in_data = 32'hCAFE_F00D;
        mode    = 2'd2;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("data_dout", dout, e_dout[i]);
            chk("data_isd", {31'b0, dout_is_data}, {31'b0, e_isd[i]});
            chk("data_cnt", {24'b0, underrun_cnt}, {24'b0, e_cnt[i]});
            chk("data_rdy", {31'b0, in_ready}, {31'b0, e_rdy[i]});
            if (i == 3) in_valid = 1'b0;
        end
        for (int k = 0; k < 300; k++) begin
            tick;
            chk("sat_cnt", {24'b0, underrun_cnt}, (4 + k > 255) ? 32'd255 : 32'(4 + k));
        end
        mode = 2'd1;
        tick;
        tick;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("clk_dout", dout, 32'hAAAA_AAAA);
            chk("clk_isd", {31'b0, dout_is_data}, 32'h0);
        end
        // queue two words in clock mode; they must stay queued and not disturb dout
        in_valid = 1'b1;
        in_data  = 32'h5555_0001;
        tick;
        in_data  = 32'h5555_0002;
        tick;
        in_valid = 1'b0;
        chk("hold_dout", dout, 32'hAAAA_AAAA);
        chk("hold_rdy", {31'b0, in_ready}, 32'h1);
        rstb = 1'b0;
        #1;
        chk("arst_dout", dout, 32'h0);
        chk("arst_isd", {31'b0, dout_is_data}, 32'h0);
        chk("arst_rdy", {31'b0, in_ready}, 32'h1);
        chk("arst_cnt", {24'b0, underrun_cnt}, 32'h0);
        mode = 2'd0;
        @(negedge clk);
        rstb = 1'b1;
        // three pushes must all be accepted if reset emptied the queue
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h7700_0000 + 32'(i);
            tick;
            chk("pf_rdy", {31'b0, in_ready}, 32'h1);
        end
        flush   = 1'b1;
        in_data = 32'h7700_00FF;
        tick;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_rdy", {31'b0, in_ready}, 32'h1);
        mode = 2'd2;
        tick;
        chk("fl_cnt0", {24'b0, underrun_cnt}, 32'h0);
        tick;
        chk("fl_cnt1", {24'b0, underrun_cnt}, 32'h0);
        tick;
        chk("fl_dout", dout, 32'h0);
        chk("fl_isd", {31'b0, dout_is_data}, 32'h0);
        chk("fl_cnt2", {24'b0, underrun_cnt}, 32'h1);
        tick;
        chk("fl_cnt3", {24'b0, underrun_cnt}, 32'h2);
        mode = 2'd0;
        tick;
        tick;
        tick;
        mode = 2'd3;
        tick;
        tick;
`ifdef TX_WORD_FEEDER_PRBS_EN
        // reference sequence: b[k] = b[k-31] ^ b[k-28], seeded by 31 ones
        for (int i = 0; i < 31; i++) hist.push_back(1'b1);
        for (int w = 0; w < 200; w++) begin
            for (int b = 0; b < 32; b++) begin
                pw[b] = hist[0] ^ hist[3];
                hist.push_back(pw[b]);
                void'(hist.pop_front());
            end
            tick;
            if (w == 0) chk("prbs_first", dout, 32'h7000_0000);
            chk("prbs_word", dout, pw);
            chk("prbs_isd", {31'b0, dout_is_data}, 32'h0);
        end
`else
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("m3_dout", dout, 32'h0);
            chk("m3_isd", {31'b0, dout_is_data}, 32'h0);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
